// File: rtl/conv_last_to_first_with_ready.sv
// Two-entry skid buffer that converts an upstream "last" marker into a downstream
// "first" marker plus a saturating zero-based beat index within the packet.
module conv_last_to_first_with_ready #(
  parameter int width       = 8,
  parameter int index_width = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   up_valid,
  input  logic                   up_last,
  input  logic [width-1:0]       up_data,
  output logic                   up_ready,
  output logic                   down_valid,
  output logic                   down_first,
  output logic [width-1:0]       down_data,
  output logic [index_width-1:0] down_index,
  input  logic                   down_ready
);

  // Handshake: a beat moves on a rising edge only when valid and ready are both 1
  // in that cycle; valid never depends on ready, and up_ready is a flop (skid empty).
  typedef struct packed {
    logic                   first;
    logic [index_width-1:0] index;
    logic [width-1:0]       data;
  } beat_t;

  localparam logic [index_width-1:0] IDX_MAX = '1;
  localparam logic [index_width-1:0] IDX_ONE = 1;

  logic                   out_valid_q, out_valid_d;
  beat_t                  out_q, out_d;
  logic                   skid_valid_q, skid_valid_d;
  beat_t                  skid_q, skid_d;
  logic                   up_ready_q, up_ready_d;
  logic                   start_q, start_d;
  logic [index_width-1:0] cnt_q, cnt_d;

  logic  up_xfer;
  logic  out_free;
  beat_t new_beat;

  always_comb begin
    up_xfer  = up_valid & up_ready_q;
    out_free = ~out_valid_q | down_ready;

    new_beat.first = start_q;
    new_beat.index = start_q ? '0 : ((cnt_q == IDX_MAX) ? cnt_q : cnt_q + IDX_ONE);
    new_beat.data  = up_data;

    start_d = up_xfer ? up_last : start_q;
    cnt_d   = up_xfer ? new_beat.index : cnt_q;

    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    // A waiting skid entry always moves ahead of a beat arriving in the same cycle.
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        skid_valid_d = up_xfer;
        skid_d       = up_xfer ? new_beat : '0;
      end else begin
        out_valid_d = up_xfer;
        out_d       = up_xfer ? new_beat : '0;
      end
    end else if (up_xfer) begin
      skid_valid_d = 1'b1;
      skid_d       = new_beat;
    end

    up_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      up_ready_q   <= 1'b0;
      start_q      <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      up_ready_q   <= up_ready_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
    end
  end

  assign up_ready   = up_ready_q;
  assign down_valid = out_valid_q;
  assign down_first = out_q.first;
  assign down_index = out_q.index;
  assign down_data  = out_q.data;

endmodule
